control_logic: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor core: PC, built-in instruction ROM, 32x32 register file, ALU, data RAM and main decoder in one top.
- No external bus; observability is through three combinational debug outputs: ALU result, data-memory read data, sign-extended immediate.
- Used as the processor top in simulation: free-running clock, reset pulse, outputs monitored.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/mips_alu.sv | 27 ++
 rtl/control_logic.sv | 177 +++++++++++++++++
 tb/tb_control_logic.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes, function
// codes, ALU operation select, decoded control bundle and the program ROM image.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

  // Decoded control for one instruction. alu_en gates aluout so that
  // NOPs and jumps present zero instead of a meaningless ALU value.
  typedef struct packed {
    logic      reg_write;
    logic      dst_rd;
    logic      alu_src_imm;
    logic      mem_write;
    logic      mem_to_reg;
    logic      branch;
    logic      jump;
    logic      alu_en;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:   1'b0,
    dst_rd:      1'b0,
    alu_src_imm: 1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    branch:      1'b0,
    jump:        1'b0,
    alu_en:      1'b0,
    alu_ctrl:    ALU_ADD
  };

  // Fixed program image; every word past the program reads as zero (NOP).
  function automatic logic [31:0] rom_word(input int idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'h20010005; // addi $1,$0,5
      1:       w = 32'h2002FFFD; // addi $2,$0,-3
      2:       w = 32'h00221820; // add  $3,$1,$2
      3:       w = 32'hAC030004; // sw   $3,4($0)
      4:       w = 32'h8C040004; // lw   $4,4($0)
      5:       w = 32'h00222822; // sub  $5,$1,$2
      6:       w = 32'h0041302A; // slt  $6,$2,$1
      7:       w = 32'h10C60001; // beq  $6,$6,+1
      8:       w = 32'h20070063; // addi $7,$0,99
      9:       w = 32'h08000009; // j    9
      default: w = 32'h00000000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU: add/sub/and/or/signed set-less-than with a zero flag for beq.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_e   ctrl,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select; arithmetic wraps modulo 2^32.
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/control_logic.sv
// Single-cycle MIPS-subset core with built-in program ROM, register file,
// data RAM and decoder. Debug outputs expose the current instruction's ALU
// result, the data RAM word it addresses, and its sign-extended immediate.
module control_logic
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] aluout,
  output logic [31:0] dataout,
  output logic [31:0] signvalue
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;

  logic [31:0] rom_mem [IMEM_WORDS];
  logic [31:0] rf_reg  [1:31];
  logic [31:0] dmem_reg [DMEM_WORDS];

  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] simm;
  ctrl_t       ctrl;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [DMEM_AW-1:0] dmem_idx;

  genvar gi;

  // Program ROM built from the package image.
  generate
    for (gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
      assign rom_mem[gi] = rom_word(gi);
    end
  endgenerate

  // Fetch and field split; the ROM wraps because only the low PC bits index it.
  assign instr     = rom_mem[pc_reg[IMEM_AW+1:2]];
  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign funct     = instr[5:0];
  assign simm      = {{16{instr[15]}}, instr[15:0]};
  assign signvalue = simm;

  // Main decoder: unknown opcodes and functs fall back to a NOP.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_rd    = 1'b1;
        ctrl.alu_en    = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          default: ctrl = CTRL_NOP;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_en      = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_en      = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_en      = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_en   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  // Register $0 is not stored; it reads as zero. No write forwarding.
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_reg[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_reg[rt];
  assign alu_b  = ctrl.alu_src_imm ? simm : rt_val;

  mips_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .ctrl   (ctrl.alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign aluout   = ctrl.alu_en ? alu_result : 32'd0;
  assign dmem_idx = aluout[DMEM_AW+1:2];
  assign dataout  = dmem_reg[dmem_idx];

  assign wr_addr = ctrl.dst_rd ? rd : rt;
  assign wr_data = ctrl.mem_to_reg ? dataout : alu_result;

  // Register file rows 1..31; reset clears them, writes to $0 never land.
  generate
    for (gi = 1; gi < 32; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (reset) begin
          rf_reg[gi] <= '0;
        end else if (ctrl.reg_write && (wr_addr == 5'(gi))) begin
          rf_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Data RAM words; cleared on reset so a restarted program sees zeros.
  generate
    for (gi = 0; gi < DMEM_WORDS; gi++) begin : g_dmem
      always_ff @(posedge clk) begin
        if (reset) begin
          dmem_reg[gi] <= '0;
        end else if (ctrl.mem_write && (dmem_idx == DMEM_AW'(gi))) begin
          dmem_reg[gi] <= rt_val;
        end
      end
    end
  endgenerate

  // Next-PC selection: sequential, taken branch, or jump.
  assign pc_plus4 = pc_reg + 32'd4;
  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.branch && alu_zero) begin
      pc_next = pc_plus4 + {simm[29:0], 2'b00};
    end
    if (ctrl.jump) begin
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: tb/tb_control_logic.sv
// Bench for control_logic: directed cycle table for the fixed program,
// hand-written mid-program reset sequence, and random reset timing checked
// against an instruction-level interpreter of the same program.
module tb_control_logic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] aluout;
  logic [31:0] dataout;
  logic [31:0] signvalue;

  control_logic #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .aluout    (aluout),
    .dataout   (dataout),
    .signvalue (signvalue)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef enum {K_NOP, K_ADDI, K_ADD, K_SUB, K_SLT, K_SW, K_LW, K_BEQ, K_J} kind_e;
  typedef struct {
    kind_e       kind;
    int unsigned d;
    int unsigned s;
    int unsigned t;
    logic [31:0] imm;
  } prog_t;

  prog_t       prog [10];
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];

  function automatic prog_t fetch(input logic [31:0] pc);
    int    idx;
    prog_t nop;
    nop = '{K_NOP, 0, 0, 0, 32'h0};
    idx = int'(pc[7:2]);
    if (idx < 10) return prog[idx];
    return nop;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
  endtask

  // Expected debug outputs for the instruction at the model PC.
  task automatic model_eval(output logic [31:0] alu, output logic [31:0] sv,
                            output logic [31:0] dout, output bit alu_known);
    prog_t       p;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] f16;
    p = fetch(m_pc);
    a = m_regs[p.s];
    b = m_regs[p.t];
    alu_known = 1'b1;
    alu = 32'd0;
    f16 = 16'd0;
    case (p.kind)
      K_ADDI, K_SW, K_LW: begin alu = a + p.imm; f16 = p.imm[15:0]; end
      K_ADD: begin alu = a + b; f16 = 16'((p.d << 11) | 32'h20); end
      K_SUB: begin alu = a - b; f16 = 16'((p.d << 11) | 32'h22); end
      K_SLT: begin alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; f16 = 16'((p.d << 11) | 32'h2A); end
      K_BEQ: begin alu = a - b; f16 = p.imm[15:0]; end
      K_J:   begin alu_known = 1'b0; f16 = p.imm[15:0]; end
      default: begin alu = 32'd0; f16 = 16'd0; end
    endcase
    sv = sext16(f16);
    dout = m_mem[alu[7:2]];
  endtask

  // Execute the instruction at the model PC.
  task automatic model_step();
    prog_t       p;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ea;
    logic [31:0] pc4;
    logic [31:0] nxt;
    p   = fetch(m_pc);
    a   = m_regs[p.s];
    b   = m_regs[p.t];
    ea  = a + p.imm;
    pc4 = m_pc + 32'd4;
    nxt = pc4;
    case (p.kind)
      K_ADDI: m_regs[p.t] = ea;
      K_ADD:  m_regs[p.d] = a + b;
      K_SUB:  m_regs[p.d] = a - b;
      K_SLT:  m_regs[p.d] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_LW:   m_regs[p.t] = m_mem[ea[7:2]];
      K_SW:   m_mem[ea[7:2]] = b;
      K_BEQ:  if (a == b) nxt = pc4 + (p.imm << 2);
      K_J:    nxt = (pc4 & 32'hF000_0000) | (p.imm << 2);
      default: ;
    endcase
    m_regs[0] = 32'd0;
    m_pc = nxt;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] sv;
    logic [31:0] dout;
  } vec_t;

  vec_t        vt [8];
  logic [31:0] exp_regs [8];

  initial begin
    logic [31:0] e_alu;
    logic [31:0] e_sv;
    logic [31:0] e_do;
    bit          e_known;
    bit          rst_now;

    prog[0] = '{K_ADDI, 0, 0, 1, 32'd5};
    prog[1] = '{K_ADDI, 0, 0, 2, 32'hFFFF_FFFD};
    prog[2] = '{K_ADD,  3, 1, 2, 32'd0};
    prog[3] = '{K_SW,   0, 0, 3, 32'd4};
    prog[4] = '{K_LW,   0, 0, 4, 32'd4};
    prog[5] = '{K_SUB,  5, 1, 2, 32'd0};
    prog[6] = '{K_SLT,  6, 2, 1, 32'd0};
    prog[7] = '{K_BEQ,  0, 6, 6, 32'd1};
    prog[8] = '{K_ADDI, 0, 0, 7, 32'd99};
    prog[9] = '{K_J,    0, 0, 0, 32'd9};

    vt[0] = '{32'd0,  32'd5,          32'd5,          32'd0};
    vt[1] = '{32'd4,  32'hFFFF_FFFD,  32'hFFFF_FFFD,  32'd0};
    vt[2] = '{32'd8,  32'd2,          32'h0000_1820,  32'd0};
    vt[3] = '{32'd12, 32'd4,          32'd4,          32'd0};
    vt[4] = '{32'd16, 32'd4,          32'd4,          32'd2};
    vt[5] = '{32'd20, 32'd8,          32'h0000_2822,  32'd0};
    vt[6] = '{32'd24, 32'd1,          32'h0000_302A,  32'd0};
    vt[7] = '{32'd28, 32'd0,          32'd1,          32'd0};

    exp_regs = '{32'd0, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd2, 32'd8, 32'd1, 32'd0};

    // Reset held two cycles.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] cycle %0d pc=%08h alu=%08h sv=%08h dout=%08h",
               i, dut.pc_reg, aluout, signvalue, dataout);
      chk($sformatf("dir%0d_pc", i), dut.pc_reg, vt[i].pc);
      chk($sformatf("dir%0d_alu", i), aluout, vt[i].alu);
      chk($sformatf("dir%0d_sv", i), signvalue, vt[i].sv);
      chk($sformatf("dir%0d_dout", i), dataout, vt[i].dout);
      tick();
    end
    // Branch taken: skips instruction 8 and lands on the self-loop.
    chk("beq_target_pc", dut.pc_reg, 32'd36);
    for (int i = 9; i < 20; i++) tick();
    chk("halt_pc", dut.pc_reg, 32'd36);
    for (int r = 1; r < 8; r++) begin
      chk($sformatf("reg%0d", r), dut.rf_reg[r], exp_regs[r]);
    end
    $display("[TB] register probe done after 20 cycles");

    // Mid-program reset at cycle 6 for one cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_pc", dut.pc_reg, 32'd24);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("[TB] mid reset pc=%08h alu=%08h", dut.pc_reg, aluout);
    chk("midrst_pc", dut.pc_reg, 32'd0);
    chk("midrst_alu", aluout, 32'd5);
    chk("midrst_reg3", dut.rf_reg[3], 32'd0);
    chk("midrst_dmem", dut.dmem_reg[1], 32'd0);
    for (int i = 0; i < 4; i++) tick();
    $display("[TB] rerun lw alu=%08h dout=%08h", aluout, dataout);
    chk("rerun_lw_alu", aluout, 32'd4);
    chk("rerun_lw_dout", dataout, 32'd2);

    // Random reset timing against the interpreter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 300; n++) begin
      model_eval(e_alu, e_sv, e_do, e_known);
      $display("[TB] rnd %0d pc=%08h alu=%08h sv=%08h dout=%08h", n, dut.pc_reg, aluout, signvalue, dataout);
      chk("rnd_pc", dut.pc_reg, m_pc);
      chk("rnd_sv", signvalue, e_sv);
      if (e_known) begin
        chk("rnd_alu", aluout, e_alu);
        chk("rnd_dout", dataout, e_do);
      end
      rst_now = ($urandom_range(0, 24) == 0);
      reset = rst_now;
      tick();
      reset = 1'b0;
      if (rst_now) model_reset();
      else model_step();
    end
    for (int r = 1; r < 8; r++) begin
      chk($sformatf("rnd_reg%0d", r), dut.rf_reg[r], m_regs[r]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
